// File: rtl/video_stream_tx.sv
// Pixel-stream to 3-bit RGB video transmitter: raster timing, 4-entry pixel FIFO, frame alignment.
// Optional VIDEO_TX_PATTERN_EN: pixels left black by HUNT/ARMED/underflow show colour bars hpos[7:5].
module video_stream_tx #(
   parameter int H_DISPLAY = 256,
   parameter int H_FRONT   = 7,
   parameter int H_SYNC    = 23,
   parameter int H_BACK    = 23,
   parameter int V_DISPLAY = 240,
   parameter int V_BOTTOM  = 14,
   parameter int V_SYNC    = 3,
   parameter int V_TOP     = 5,
   parameter int PIX_DIV   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [2:0]  pix_data,
   input  logic        pix_sof,
   output logic        pix_ready,
   output logic        hsync,
   output logic        vsync,
   output logic [2:0]  rgb,
   output logic        display_on,
   output logic [8:0]  hpos,
   output logic [8:0]  vpos,
   output logic [15:0] frame_cnt,
   output logic        underflow,
   output logic        sync_err
);

   localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
   localparam int HS_START = H_DISPLAY + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_DISPLAY + V_BOTTOM;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   typedef enum logic [1:0] {HUNT, ARMED, STREAM} state_t;

   state_t             state, state_nxt;
   logic [DIV_W-1:0]   div;
   logic               tick;
   logic [8:0]         h_nxt, v_nxt;
   logic               frame_wrap, vis_nxt, origin_nxt;
   logic [3:0]         mem [4];
   logic [3:0]         head;
   logic [1:0]         rd_ptr, wr_ptr;
   logic [2:0]         count, count_nxt;
   logic               push, store, pop, flush;
   logic [2:0]         rgb_nxt, fill;
   logic               underflow_nxt, sync_err_nxt;

   assign tick = (div == DIV_W'(PIX_DIV - 1));
   assign push = pix_valid && pix_ready;
   assign head = mem[rd_ptr];

`ifdef VIDEO_TX_PATTERN_EN
   assign fill = h_nxt[7:5];
`else
   assign fill = 3'd0;
`endif

   // Position the raster moves to on the next tick; colour is resolved for that position.
   always_comb begin
      h_nxt      = hpos + 9'd1;
      v_nxt      = vpos;
      frame_wrap = 1'b0;
      if (hpos == 9'(H_TOTAL - 1)) begin
         h_nxt = '0;
         if (vpos == 9'(V_TOTAL - 1)) begin
            v_nxt      = '0;
            frame_wrap = 1'b1;
         end else begin
            v_nxt = vpos + 9'd1;
         end
      end
      vis_nxt    = (h_nxt < 9'(H_DISPLAY)) && (v_nxt < 9'(V_DISPLAY));
      origin_nxt = (h_nxt == '0) && (v_nxt == '0);
   end

   always_comb begin
      state_nxt     = state;
      pop           = 1'b0;
      flush         = 1'b0;
      rgb_nxt       = rgb;
      underflow_nxt = 1'b0;
      sync_err_nxt  = 1'b0;
      store         = push;
      if (tick) begin
         rgb_nxt = '0;
         if (vis_nxt) begin
            case (state)
               HUNT: rgb_nxt = fill;
               ARMED: begin
                  if (origin_nxt) begin
                     pop       = 1'b1;
                     rgb_nxt   = head[2:0];
                     state_nxt = STREAM;
                  end else begin
                     rgb_nxt = fill;
                  end
               end
               STREAM: begin
                  if (count == 3'd0) begin
                     underflow_nxt = 1'b1;
                     rgb_nxt       = fill;
                  end else if (head[3] != origin_nxt) begin
                     flush        = 1'b1;
                     sync_err_nxt = 1'b1;
                     state_nxt    = HUNT;
                  end else begin
                     pop     = 1'b1;
                     rgb_nxt = head[2:0];
                  end
               end
               default: state_nxt = HUNT;
            endcase
         end
      end
      // While hunting the FIFO is empty; only a start-of-frame entry may enter it.
      if (state == HUNT) begin
         store = push && pix_sof;
         if (store) state_nxt = ARMED;
      end
      if (flush) store = 1'b0;
      count_nxt = flush ? 3'd0 : (count + {2'b0, store} - {2'b0, pop});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div        <= '0;
         hpos       <= '0;
         vpos       <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         display_on <= 1'b1;
         rgb        <= '0;
         frame_cnt  <= '0;
         underflow  <= 1'b0;
         sync_err   <= 1'b0;
         pix_ready  <= 1'b0;
         state      <= HUNT;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         pix_ready <= (count_nxt < 3'd4);
         underflow <= underflow_nxt;
         sync_err  <= sync_err_nxt;
         rgb       <= rgb_nxt;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (store) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
         end
         if (tick) begin
            div        <= '0;
            hpos       <= h_nxt;
            vpos       <= v_nxt;
            hsync      <= !((h_nxt >= 9'(HS_START)) && (h_nxt < 9'(HS_END)));
            vsync      <= !((v_nxt >= 9'(VS_START)) && (v_nxt < 9'(VS_END)));
            display_on <= vis_nxt;
            if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr] <= {pix_sof, pix_data};
   end

endmodule

// File: tb/tb_video_stream_tx.sv
// Randomised self-checking bench for video_stream_tx: a raster/stream model derived from clock counts.
module tb_video_stream_tx;

   localparam int HD = 16, HF = 2, HS = 3, HB = 2;
   localparam int VD = 6, VB = 2, VS = 1, VTP = 1, PD = 2;
   localparam int HT = HD + HF + HS + HB;   // 23
   localparam int VT = VD + VB + VS + VTP;  // 10
   localparam int HUNT = 0, ARMED = 1, STREAM = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_valid = 1'b0, pix_sof = 1'b0;
   logic [2:0]  pix_data = '0;
   logic        pix_ready, hsync, vsync, display_on, underflow, sync_err;
   logic [2:0]  rgb;
   logic [8:0]  hpos, vpos;
   logic [15:0] frame_cnt;
   logic        d_ready, d_hsync, d_vsync, d_display_on, d_underflow, d_sync_err;
   logic [2:0]  d_rgb;
   logic [8:0]  d_hpos, d_vpos;
   logic [15:0] d_frame_cnt;

   video_stream_tx #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                     .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VTP), .PIX_DIV(PD)) dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
      .pix_ready(pix_ready), .hsync(hsync), .vsync(vsync), .rgb(rgb), .display_on(display_on),
      .hpos(hpos), .vpos(vpos), .frame_cnt(frame_cnt), .underflow(underflow), .sync_err(sync_err));

   video_stream_tx dflt (
      .clk(clk), .reset(reset), .pix_valid(1'b0), .pix_data(3'd0), .pix_sof(1'b0),
      .pix_ready(d_ready), .hsync(d_hsync), .vsync(d_vsync), .rgb(d_rgb), .display_on(d_display_on),
      .hpos(d_hpos), .vpos(d_vpos), .frame_cnt(d_frame_cnt), .underflow(d_underflow),
      .sync_err(d_sync_err));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int n, ms, px, py, stall;
   logic [3:0] q[$];
   logic [2:0] m_rgb;
   logic m_uf, m_se, m_ready, m_push;
   bit dflt_on;
   int cnt_uf, cnt_se, cnt_hs, cnt_vs, cnt_dhs, pin_frame;
   logic [2:0] pin;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
      end
   endtask

   function automatic logic [2:0] fill(int h);
      logic [2:0] r;
      r = 3'((h >> 5) & 7);
`ifndef VIDEO_TX_PATTERN_EN
      r = 3'd0;
`endif
      return r;
   endfunction

   task automatic model_reset();
      n = 0; q.delete(); ms = HUNT;
      m_rgb = '0; m_uf = 1'b0; m_se = 1'b0; m_ready = 1'b0;
   endtask

   // One clock edge of the transmitter as described by its operating rules.
   task automatic model_step();
      int t, h, v, old;
      bit vis, org, flush;
      m_push = pix_valid && m_ready;
      old = ms; flush = 0; n++;
      m_uf = 1'b0; m_se = 1'b0;
      if (n % PD == 0) begin
         t = n / PD; h = t % HT; v = (t / HT) % VT;
         vis = (h < HD) && (v < VD); org = (h == 0) && (v == 0);
         m_rgb = '0;
         if (vis) begin
            if (ms == HUNT) m_rgb = fill(h);
            else if (ms == ARMED) begin
               if (org) begin m_rgb = q[0][2:0]; void'(q.pop_front()); ms = STREAM; end
               else m_rgb = fill(h);
            end else if (q.size() == 0) begin
               m_uf = 1'b1; m_rgb = fill(h);
            end else if (q[0][3] != org) begin
               flush = 1; m_se = 1'b1; ms = HUNT;
            end else begin
               m_rgb = q[0][2:0]; void'(q.pop_front());
            end
         end
      end
      if (flush) q.delete();
      else if (m_push) begin
         if (old != HUNT) q.push_back({pix_sof, pix_data});
         else if (pix_sof) begin q.push_back({pix_sof, pix_data}); ms = ARMED; end
      end
      m_ready = (q.size() < 4);
   endtask

   task automatic compare();
      int t, h, v;
      t = n / PD; h = t % HT; v = (t / HT) % VT;
      check("hpos", 32'(hpos), 32'(h));
      check("vpos", 32'(vpos), 32'(v));
      check("hsync", 32'(hsync), 32'(!(h >= HD + HF && h < HD + HF + HS)));
      check("vsync", 32'(vsync), 32'(!(v >= VD + VB && v < VD + VB + VS)));
      check("display_on", 32'(display_on), 32'(h < HD && v < VD));
      check("rgb", 32'(rgb), 32'(m_rgb));
      check("underflow", 32'(underflow), 32'(m_uf));
      check("sync_err", 32'(sync_err), 32'(m_se));
      check("pix_ready", 32'(pix_ready), 32'(m_ready));
      check("frame_cnt", 32'(frame_cnt), 32'((t / (HT * VT)) % 65536));
   endtask

   task automatic compare_dflt();
      int t, h, v;
      t = n / 2; h = t % 309; v = (t / 309) % 262;
      check("d_hpos", 32'(d_hpos), 32'(h));
      check("d_vpos", 32'(d_vpos), 32'(v));
      check("d_hsync", 32'(d_hsync), 32'(!(h >= 263 && h < 286)));
      check("d_vsync", 32'(d_vsync), 32'(!(v >= 254 && v < 257)));
      check("d_display_on", 32'(d_display_on), 32'(h < 256 && v < 240));
      check("d_rgb", 32'(d_rgb), 32'd0);
      check("d_pulses", 32'({d_underflow, d_sync_err}), 32'd0);
      check("d_ready", 32'(d_ready), 32'(n > 0));
      check("d_frame_cnt", 32'(d_frame_cnt), 32'(t / (309 * 262)));
   endtask

   task automatic drive(int mode);
      if (mode == 0) begin
         pix_valid = 1'b0;
      end else if (mode == 1) begin
         pix_valid = 1'b1;
         pix_data  = 3'(px & 7);
      end else begin
         if (stall > 0) begin
            pix_valid = 1'b0; stall--;
         end else begin
            pix_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) stall = 20;
            if ($urandom_range(0, 499) == 0) begin px = 0; py = 0; end
         end
         pix_data = 3'($urandom_range(0, 7));
      end
      pix_sof = (px == 0) && (py == 0);
   endtask

   task automatic run(int k, int mode);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         m_push = 1'b0;
         if (!reset) model_step();
         if (m_push) begin
            px++;
            if (px == HD) begin px = 0; py++; if (py == VD) py = 0; end
         end
         @(negedge clk);
         compare();
         if (dflt_on) compare_dflt();
         if (!reset) begin
            cnt_uf += int'(underflow); cnt_se += int'(sync_err);
            cnt_hs += int'(!hsync); cnt_vs += int'(!vsync); cnt_dhs += int'(!d_hsync);
         end
         if (hpos == 9'd5 && vpos == 9'd1 && frame_cnt == 16'(pin_frame)) pin = rgb;
         drive(mode);
      end
   endtask

   task automatic clear_tallies();
      cnt_uf = 0; cnt_se = 0; cnt_hs = 0; cnt_vs = 0; cnt_dhs = 0;
   endtask

   initial begin
      bit found;
      reset = 1'b1;
      model_reset(); px = 0; py = 0; stall = 0; pin = 3'd7; pin_frame = 5;
      dflt_on = 1'b1; clear_tallies();
      run(7, 0);
      reset = 1'b0;

      // Idle raster: literal sync counts over 1900 clocks for both geometries.
      clear_tallies();
      run(1900, 0);
      check("lit_hsync_low_clocks", 32'(cnt_hs), 32'd246);
      check("lit_vsync_low_clocks", 32'(cnt_vs), 32'd184);
      check("lit_dflt_hsync_low_clocks", 32'(cnt_dhs), 32'd138);
      check("lit_frame_cnt_idle", 32'(frame_cnt), 32'd4);
      check("lit_dflt_hpos", 32'(d_hpos), 32'd23);
      check("lit_dflt_vpos", 32'(d_vpos), 32'd3);
      dflt_on = 1'b0;

      // Clean stream, data = column[2:0], first streamed frame is frame_cnt 5.
      px = 0; py = 0; clear_tallies();
      run(1200, 1);
      check("lit_stream_underflows", 32'(cnt_uf), 32'd0);
      check("lit_stream_sync_errs", 32'(cnt_se), 32'd0);
      check("lit_pixel_5_1", 32'(pin), 32'd5);

      // Random valid gaps, stalls and early start-of-frame entries.
      clear_tallies();
      run(3000, 2);
      $display("random phase: %0d underflow pulses, %0d sync_err pulses", cnt_uf, cnt_se);

      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         run(1, 2);
         if (((n / PD) % HT) == 10 && (((n / PD) / HT) % VT) == 3) found = 1;
      end
      check("reach_pos_10_3", 32'(found), 32'd1);

      // Asynchronous reset mid-frame.
      reset = 1'b1;
      #1;
      check("rst_hpos", 32'(hpos), 32'd0);
      check("rst_vpos", 32'(vpos), 32'd0);
      check("rst_syncs", 32'({hsync, vsync}), 32'd3);
      check("rst_rgb", 32'(rgb), 32'd0);
      check("rst_display_on", 32'(display_on), 32'd1);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_pulses", 32'({underflow, sync_err}), 32'd0);
      check("rst_ready", 32'(pix_ready), 32'd0);
      model_reset(); px = 0; py = 0; stall = 0;
      run(3, 2);
      reset = 1'b0;
      pin = 3'd7; pin_frame = 1; clear_tallies();
      run(2, 1);
      check("lit_hpos_after_restart", 32'(hpos), 32'd1);
      run(1000, 1);
      check("lit_restart_pixel_5_1", 32'(pin), 32'd5);
      check("lit_restart_sync_errs", 32'(cnt_se), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
